// File: rtl/edge_pkg.sv
// Shared types for the streaming edge detector: line FSM encoding and the
// tap ordering of the packed kernel window {up, right, down, left}.
package edge_pkg;

  typedef enum logic [1:0] {
    LINE0 = 2'd0,
    LINE1 = 2'd1,
    RUN   = 2'd2
  } line_state_t;

  localparam int NUM_TAPS  = 4;
  localparam int WIN_LEFT  = 0;
  localparam int WIN_DOWN  = 1;
  localparam int WIN_RIGHT = 2;
  localparam int WIN_UP    = 3;

endpackage

// File: rtl/line_buffer.sv
// Simple dual-port line store: one write port, one registered read port.
// Contents are deliberately not reset.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stream_edge_detect.sv
// Streaming 3x3-cross edge detector with a runtime threshold and valid/ready
// on both sides. Define STREAM_EDGE_MAGNITUDE_EN to add out_magnitude.
module stream_edge_detect
  import edge_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter int PIXEL_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] threshold,
  input  logic [PIXEL_BITS-1:0] in_pixel,
  input  logic                  in_sof,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_edge_x,
  output logic                  out_edge_y,
  output logic                  out_eol,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef STREAM_EDGE_MAGNITUDE_EN
  ,output logic [PIXEL_BITS-1:0] out_magnitude
`endif
);

  localparam int PB = PIXEL_BITS;
  localparam int CW = $clog2(LINE_WIDTH);
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_WIDTH - 1);

  line_state_t state, state_nxt;
  logic [CW-1:0] col, col_eff, col_nxt;
  logic accept, result;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_eff  = in_sof ? '0 : col;
  assign col_nxt  = (col_eff == LAST_COL) ? '0 : col_eff + 1'b1;

  always_comb begin
    state_nxt = state;
    result    = 1'b0;
    if (accept) begin
      if (in_sof) begin
        state_nxt = LINE0;
      end else begin
        result = (state == RUN) && (col >= CW'(2));
        if (col == LAST_COL) begin
          case (state)
            LINE0:   state_nxt = LINE1;
            default: state_nxt = RUN;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= LINE0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) col <= col_nxt;
    end
  end

  // Buffer 0 holds the previous line, buffer 1 the one before; buffer 1 is
  // fed from buffer 0's read data so both shift together per column.
  logic [1:0][PB-1:0] lb_wr, lb_rd;
  assign lb_wr = {lb_rd[0], in_pixel};

  for (genvar i = 0; i < 2; i++) begin : g_lb
    line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PB)) u_lb (
      .clock (clock),
      .we    (accept),
      .waddr (col_eff),
      .wdata (lb_wr[i]),
      .re    (accept),
      .raddr (col_nxt),
      .rdata (lb_rd[i])
    );
  end

  logic [PB-1:0] pix_d1, prev_d1, prev_d2, pprev_d1;

  always_ff @(posedge clock) begin
    if (accept) begin
      pix_d1   <= in_pixel;
      prev_d1  <= lb_rd[0];
      prev_d2  <= prev_d1;
      pprev_d1 <= lb_rd[1];
    end
  end

  logic [NUM_TAPS-1:0][PB-1:0] win;
  always_comb begin
    win            = '0;
    win[WIN_UP]    = pprev_d1;
    win[WIN_RIGHT] = lb_rd[0];
    win[WIN_DOWN]  = pix_d1;
    win[WIN_LEFT]  = prev_d2;
  end

  logic signed [PB:0] dx, dy;
  assign dx = $signed({1'b0, win[WIN_RIGHT]}) - $signed({1'b0, win[WIN_LEFT]});
  assign dy = $signed({1'b0, win[WIN_DOWN]})  - $signed({1'b0, win[WIN_UP]});

  // One extra bit so that -d cannot overflow when d is the most negative value.
  function automatic logic is_edge(input logic signed [PB:0] d, input logic [PB-1:0] t);
    logic signed [PB+1:0] de, te;
    de = {d[PB], d};
    te = {2'b00, t};
    return (de >= te) || (-de > te);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_edge_x <= 1'b0;
      out_edge_y <= 1'b0;
      out_eol    <= 1'b0;
    end else if (result) begin
      out_valid  <= 1'b1;
      out_edge_x <= is_edge(dx, threshold);
      out_edge_y <= is_edge(dy, threshold);
      out_eol    <= (col == LAST_COL);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef STREAM_EDGE_MAGNITUDE_EN
  logic [PB:0]   abs_x, abs_y;
  logic [PB+1:0] mag_sum;
  assign abs_x   = dx[PB] ? PB'(0) - dx : dx;
  assign abs_y   = dy[PB] ? PB'(0) - dy : dy;
  assign mag_sum = {1'b0, abs_x} + {1'b0, abs_y};

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       out_magnitude <= '0;
    else if (result) out_magnitude <= (|mag_sum[PB+1:PB]) ? '1 : mag_sum[PB-1:0];
  end
`endif

endmodule

// File: tb/tb_stream_edge_detect.sv
// Randomized scoreboard bench for stream_edge_detect (LINE_WIDTH=8, PIXEL_BITS=8).
// Also checks out_magnitude when STREAM_EDGE_MAGNITUDE_EN is defined.
module tb_stream_edge_detect;
  localparam int LW = 8;
  localparam int PB = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [PB-1:0] threshold = 8'd32;
  logic [PB-1:0] in_pixel = '0;
  logic in_sof = 1'b0, in_valid = 1'b0, in_ready;
  logic out_edge_x, out_edge_y, out_eol, out_valid;
  logic out_ready = 1'b1;
`ifdef STREAM_EDGE_MAGNITUDE_EN
  logic [PB-1:0] out_magnitude;
`endif

  always #5 clock = ~clock;

  stream_edge_detect #(.LINE_WIDTH(LW), .PIXEL_BITS(PB)) dut (
    .clock      (clock),
    .reset      (reset),
    .threshold  (threshold),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_edge_x (out_edge_x),
    .out_edge_y (out_edge_y),
    .out_eol    (out_eol),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef STREAM_EDGE_MAGNITUDE_EN
    ,.out_magnitude (out_magnitude)
`endif
  );

  typedef struct packed {
    logic ex;
    logic ey;
    logic eol;
    logic [7:0] mag;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int n_out = 0, n_ex = 0, n_ey = 0, n_eol = 0;
  int ready_mode = 0;
  int img[3][LW];
  int mr = 0, mc = 0;
  int pat[16][LW];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: image rows kept modulo 3, kernel evaluated from row/column rules.
  function automatic void model_accept(input int pix, input bit sof, input int t);
    int dx, dy, s;
    exp_t e;
    if (sof) begin mr = 0; mc = 0; end
    img[mr % 3][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      dx = img[(mr + 2) % 3][mc] - img[(mr + 2) % 3][mc - 2];
      dy = img[mr % 3][mc - 1] - img[(mr + 1) % 3][mc - 1];
      e.ex  = (dx >= t) || (dx <= -(t + 1));
      e.ey  = (dy >= t) || (dy <= -(t + 1));
      e.eol = (mc == LW - 1);
      s = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
      e.mag = (s > 255) ? 8'd255 : 8'(s);
      q.push_back(e);
    end
    mc++;
    if (mc == LW) begin mc = 0; mr++; end
  endfunction

  task automatic send(input int pix, input bit sof);
    int n = 0;
    in_pixel = 8'(pix);
    in_sof   = sof;
    in_valid = 1'b1;
    @(negedge clock);
    while (in_ready !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clock);
    end
    if (n >= 2000) check("in_ready_timeout", 0, 1);
    else model_accept(pix, sof, int'(threshold));
    @(posedge clock); #1;
    in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_rows(input int rows, input int cols_last);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < ((r == rows - 1) ? cols_last : LW); c++)
        send(pat[r][c], (r == 0 && c == 0));
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 0;
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output handshake, checks hold and ready rule.
  initial begin
    logic stall_prev = 1'b0;
    logic [3:0] saved = '0;
    logic [7:0] saved_mag = '0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (stall_prev) begin
          check("hold_outputs", {out_valid, out_edge_x, out_edge_y, out_eol}, saved);
`ifdef STREAM_EDGE_MAGNITUDE_EN
          check("hold_magnitude", out_magnitude, saved_mag);
`endif
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          n_out++;
          n_ex  += int'(out_edge_x);
          n_ey  += int'(out_edge_y);
          n_eol += int'(out_eol);
          if (q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = q.pop_front();
            check("edge_x", out_edge_x, e.ex);
            check("edge_y", out_edge_y, e.ey);
            check("eol", out_eol, e.eol);
`ifdef STREAM_EDGE_MAGNITUDE_EN
            check("magnitude", out_magnitude, e.mag);
`endif
          end
        end
        stall_prev = out_valid && !out_ready;
        saved = {out_valid, out_edge_x, out_edge_y, out_eol};
`ifdef STREAM_EDGE_MAGNITUDE_EN
        saved_mag = out_magnitude;
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int b_out, b_ex, b_ey, b_eol, rows;

    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_edge_x", out_edge_x, 0);
    check("reset_edge_y", out_edge_y, 0);
    check("reset_eol", out_eol, 0);
    check("reset_in_ready", in_ready, 1);
    #20;
    @(posedge clock); #1;
    reset = 1'b0;

    // Flat frame
    for (int r = 0; r < 4; r++) for (int c = 0; c < LW; c++) pat[r][c] = 100;
    threshold = 8'd32;
    b_out = n_out; b_ex = n_ex; b_ey = n_ey; b_eol = n_eol;
    send_rows(4, LW); drain();
    check("flat_count", n_out - b_out, 12);
    check("flat_eol_count", n_eol - b_eol, 2);
    check("flat_edges", (n_ex - b_ex) + (n_ey - b_ey), 0);

    // Vertical step at T=32 then T=33
    for (int r = 0; r < 4; r++) for (int c = 0; c < LW; c++) pat[r][c] = (c < 4) ? 10 : 42;
    for (int t = 32; t <= 33; t++) begin
      threshold = 8'(t);
      b_out = n_out; b_ex = n_ex; b_ey = n_ey;
      send_rows(4, LW); drain();
      check("vstep_count", n_out - b_out, 12);
      check("vstep_edge_x", n_ex - b_ex, (t == 32) ? 4 : 0);
      check("vstep_edge_y", n_ey - b_ey, 0);
    end

    // Negative vertical step: dy=-33 then dy=-32
    threshold = 8'd32;
    for (int v = 167; v <= 168; v++) begin
      for (int r = 0; r < 3; r++) for (int c = 0; c < LW; c++) pat[r][c] = (r < 2) ? 200 : v;
      b_out = n_out; b_ey = n_ey;
      send_rows(3, LW); drain();
      check("negstep_count", n_out - b_out, 6);
      check("negstep_edge_y", n_ey - b_ey, (v == 167) ? 6 : 0);
    end

    // Backpressure: out_ready toggling, in_valid held
    for (int r = 0; r < 4; r++) for (int c = 0; c < LW; c++) pat[r][c] = (c < 4) ? 10 : 42;
    ready_mode = 1;
    b_out = n_out; b_ex = n_ex;
    send_rows(4, LW); drain();
    check("bp_count", n_out - b_out, 12);
    check("bp_edge_x", n_ex - b_ex, 4);

    // Mid-line SOF at row 3 col 5, then a fresh 3-row frame
    ready_mode = 2;
    for (int r = 0; r < 4; r++) for (int c = 0; c < LW; c++) pat[r][c] = int'($urandom_range(0, 255));
    b_out = n_out;
    send_rows(4, 5);
    for (int r = 0; r < 3; r++) for (int c = 0; c < LW; c++) pat[r][c] = int'($urandom_range(0, 255));
    send_rows(3, LW); drain();
    check("midsof_count", n_out - b_out, 15);

    // Reset mid-RUN with a result pending
    for (int r = 0; r < 3; r++) for (int c = 0; c < LW; c++) pat[r][c] = int'($urandom_range(0, 255));
    send_rows(3, 3);
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_edges", {out_edge_x, out_edge_y, out_eol}, 0);
    check("reset_in_ready_mid", in_ready, 1);
    q.delete(); mr = 0; mc = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < LW; c++) begin
      pat[0][c] = int'($urandom_range(0, 255));
      pat[1][c] = (c < 3) ? 0 : 255;
      pat[2][c] = int'($urandom_range(0, 255));
    end
    b_out = n_out;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < LW; c++) send(pat[r][c], 1'b0);
      if (r == 1) begin
        check("post_reset_no_results", n_out - b_out, 0);
        check("post_reset_no_valid", out_valid, 0);
      end
    end
    drain();
    check("post_reset_count", n_out - b_out, 6);

    // Random frames: random threshold, gaps and backpressure
    for (int f = 0; f < 8; f++) begin
      rows = int'($urandom_range(3, 6));
      ready_mode = int'($urandom_range(0, 2));
      threshold = ($urandom_range(0, 3) == 0) ? 8'd32 : 8'($urandom_range(0, 255));
      for (int r = 0; r < rows; r++) begin
        for (int c = 0; c < LW; c++) begin
          if ($urandom_range(0, 15) == 0) threshold = 8'($urandom_range(0, 64));
          send(int'($urandom_range(0, 255)), (r == 0 && c == 0));
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
      end
      b_out = n_out;
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
